// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe: pipelined Gray<->binary converter with valid/ready handshakes; define GRAY_CODEC_PARITY_EN to add out_parity
module gray_codec_pipe #(
    parameter int WIDTH = 32,
    localparam int STEPS = (WIDTH < 2) ? 1 : $clog2(WIDTH),
    localparam int OCC_W = $clog2(STEPS + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
`ifdef GRAY_CODEC_PARITY_EN
    output logic             out_parity,
`endif
    output logic             busy,
    output logic [OCC_W-1:0] occupancy
);
    logic [STEPS-1:0] v_q, v_d, m_q, m_d, adv, src_v, src_m;
    logic [WIDTH-1:0] d_q [STEPS];
    logic [WIDTH-1:0] d_d [STEPS];
    logic [WIDTH-1:0] src_d [STEPS];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer, out_xfer, run;
`ifdef GRAY_CODEC_PARITY_EN
    logic [STEPS-1:0] p_q, p_d, src_p;
`endif

    // Gray->binary stages fold in shifts 2^(STEPS-1-k); binary->Gray is done entirely in stage 0
    function automatic logic [WIDTH-1:0] conv(input logic [WIDTH-1:0] x, input logic m, input int k);
        return m ? ((k == 0) ? x ^ (x >> 1) : x) : x ^ (x >> (1 << (STEPS - 1 - k)));
    endfunction

    // a stage advances when it or any stage downstream is empty, or the consumer takes the last word
    always_comb begin
        run = out_ready;
        for (int k = STEPS - 1; k >= 0; k--) begin
            run = run || !v_q[k];
            adv[k] = run;
        end
    end

    assign in_ready  = adv[0];
    assign in_xfer   = in_valid && adv[0];
    assign out_xfer  = v_q[STEPS-1] && out_ready;
    assign out_valid = v_q[STEPS-1];
    assign out_data  = d_q[STEPS-1];
    assign out_mode  = m_q[STEPS-1];
    assign occupancy = occ_q;
    assign busy      = occ_q != '0;
`ifdef GRAY_CODEC_PARITY_EN
    assign out_parity = p_q[STEPS-1];
`endif

    // shift words forward; payload only loads with a valid word so the output holds its last value
    always_comb begin
        src_v[0] = in_valid;
        src_m[0] = in_mode;
        src_d[0] = in_data;
`ifdef GRAY_CODEC_PARITY_EN
        src_p[0] = ^in_data;
`endif
        for (int k = 1; k < STEPS; k++) begin
            src_v[k] = v_q[k-1];
            src_m[k] = m_q[k-1];
            src_d[k] = d_q[k-1];
`ifdef GRAY_CODEC_PARITY_EN
            src_p[k] = p_q[k-1];
`endif
        end
        for (int k = 0; k < STEPS; k++) begin
            v_d[k] = adv[k] ? src_v[k] : v_q[k];
            m_d[k] = (adv[k] && src_v[k]) ? src_m[k] : m_q[k];
            d_d[k] = (adv[k] && src_v[k]) ? conv(src_d[k], src_m[k], k) : d_q[k];
`ifdef GRAY_CODEC_PARITY_EN
            p_d[k] = (adv[k] && src_v[k]) ? src_p[k] : p_q[k];
`endif
        end
        occ_d = (in_xfer == out_xfer) ? occ_q : in_xfer ? occ_q + OCC_W'(1) : occ_q - OCC_W'(1);
    end

    // pipeline state with asynchronous clear
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v_q   <= '0;
            m_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < STEPS; k++) d_q[k] <= '0;
`ifdef GRAY_CODEC_PARITY_EN
            p_q   <= '0;
`endif
        end else begin
            v_q   <= v_d;
            m_q   <= m_d;
            occ_q <= occ_d;
            for (int k = 0; k < STEPS; k++) d_q[k] <= d_d[k];
`ifdef GRAY_CODEC_PARITY_EN
            p_q   <= p_d;
`endif
        end
    end
endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe: table vectors plus scoreboarded streams for the Gray/binary pipeline at WIDTH 32, 7 and 1
module tb_gray_codec_pipe;
    logic clk = 0, nrst = 0;
    always #5 clk = ~clk;

    logic        in_valid = 0, in_mode = 0, out_ready = 1;
    logic [31:0] in_data = 0;
    logic        in_ready, out_valid, out_mode, busy;
    logic [31:0] out_data;
    logic [2:0]  occupancy;

    logic       v7 = 0, m7 = 0, r7, ov7, om7, b7;
    logic [6:0] d7 = 0, od7;
    logic [1:0] oc7;
    logic       v1 = 0, m1 = 0, d1 = 0, r1, ov1, om1, b1, od1;
    logic [0:0] oc1;
`ifdef GRAY_CODEC_PARITY_EN
    logic out_parity, p7, p1;
`endif

    gray_codec_pipe #(.WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mode(out_mode),
`ifdef GRAY_CODEC_PARITY_EN
        .out_parity(out_parity),
`endif
        .busy(busy), .occupancy(occupancy));

    gray_codec_pipe #(.WIDTH(7)) dut7 (
        .clk(clk), .nrst(nrst), .in_valid(v7), .in_ready(r7), .in_data(d7), .in_mode(m7),
        .out_valid(ov7), .out_ready(1'b1), .out_data(od7), .out_mode(om7),
`ifdef GRAY_CODEC_PARITY_EN
        .out_parity(p7),
`endif
        .busy(b7), .occupancy(oc7));

    gray_codec_pipe #(.WIDTH(1)) dut1 (
        .clk(clk), .nrst(nrst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_mode(m1),
        .out_valid(ov1), .out_ready(1'b1), .out_data(od1), .out_mode(om1),
`ifdef GRAY_CODEC_PARITY_EN
        .out_parity(p1),
`endif
        .busy(b1), .occupancy(oc1));

    typedef struct { logic [31:0] d; logic m; logic p; } exp_t;
    typedef struct { logic m; logic [31:0] din; logic [31:0] dout; } vec_t;

    exp_t sb[$], q7[$], q1[$];
    exp_t e, e7, e1;
    vec_t vecs[8];
    int pass_cnt = 0, total_cnt = 0;
    int exp_occ = 0, max_occ = 0, out_cnt = 0, acc_cnt = 0, out7_cnt = 0, out1_cnt = 0;
    int lat, a0, o0;
    logic [31:0] held_d, bx;
    logic held_m, stalled = 0, bm;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    // reference: Gray->binary bit i is the parity of Gray bits i and above
    function automatic logic [63:0] model(input logic [63:0] x, input logic m, input int w);
        logic [63:0] r = '0;
        if (m) r = x ^ (x >> 1);
        else for (int i = 0; i < w; i++) r[i] = ^(x >> i);
        return r;
    endfunction

    task automatic send(input logic [31:0] d, input logic m, input logic [31:0] want);
        int t = 0;
        logic acc = 0;
        in_valid = 1;
        in_data = d;
        in_mode = m;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) sb.push_back('{want, m, ^d});
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 0;
        in_data = $urandom;
        in_mode = 1'($urandom);
        if (!acc) check("send accepted", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || out_valid) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain queue empty", sb.size(), 0);
    endtask

    task automatic measure_latency();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency edges", lat, 4);
    endtask

    always @(negedge clk) begin
        if (!nrst) begin
            exp_occ = 0;
            stalled = 0;
        end else begin
            check("occupancy", occupancy, exp_occ);
            check("busy", busy, exp_occ != 0);
            if (stalled) begin
                check("held out_data", out_data, held_d);
                check("held out_mode", out_mode, held_m);
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) check("unexpected output", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_mode", out_mode, e.m);
`ifdef GRAY_CODEC_PARITY_EN
                    check("out_parity", out_parity, e.p);
`endif
                end
            end
            if (in_valid && in_ready) acc_cnt++;
            stalled = out_valid && !out_ready;
            held_d = out_data;
            held_m = out_mode;
            exp_occ += int'(in_valid && in_ready) - int'(out_valid && out_ready);
            if (exp_occ > max_occ) max_occ = exp_occ;
        end
    end

    always @(negedge clk) begin
        if (nrst) begin
            if (v7 && r7) q7.push_back('{32'(model(64'(d7), m7, 7)), m7, ^d7});
            if (v1 && r1) q1.push_back('{32'(model(64'(d1), m1, 1)), m1, d1});
            if (ov7) begin
                out7_cnt++;
                if (q7.size() == 0) check("w7 unexpected output", 1, 0);
                else begin
                    e7 = q7.pop_front();
                    check("w7 out_data", od7, e7.d);
                    check("w7 out_mode", om7, e7.m);
`ifdef GRAY_CODEC_PARITY_EN
                    check("w7 out_parity", p7, e7.p);
`endif
                end
            end
            if (ov1) begin
                out1_cnt++;
                if (q1.size() == 0) check("w1 unexpected output", 1, 0);
                else begin
                    e1 = q1.pop_front();
                    check("w1 out_data", od1, e1.d);
                    check("w1 out_mode", om1, e1.m);
`ifdef GRAY_CODEC_PARITY_EN
                    check("w1 out_parity", p1, e1.p);
`endif
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 32'h00000007, 32'h00000005};
        vecs[1] = '{1'b0, 32'h80000000, 32'hFFFFFFFF};
        vecs[2] = '{1'b1, 32'h00000005, 32'h00000007};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h80000000};
        vecs[4] = '{1'b0, 32'h00000007, 32'h00000005};
        vecs[5] = '{1'b0, 32'h00000003, 32'h00000002};
        vecs[6] = '{1'b0, 32'hFFFFFFFF, 32'hAAAAAAAA};
        vecs[7] = '{1'b1, 32'h12345678, 32'h1B2E7D44};

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_mode", out_mode, 0);
        check("reset occupancy", occupancy, 0);
        check("reset busy", busy, 0);
        check("reset w7 out_valid", ov7, 0);
        check("reset w1 out_valid", ov1, 0);
`ifdef GRAY_CODEC_PARITY_EN
        check("reset out_parity", out_parity, 0);
`endif
        nrst = 1;
        @(posedge clk);
        #1;

        send(32'h7, 1'b0, 32'h5);
        measure_latency();
        drain();
        send(32'h80000000, 1'b0, 32'hFFFFFFFF);
        drain();

        max_occ = 0;
        for (int i = 0; i < 8; i++) send(vecs[i].din, vecs[i].m, vecs[i].dout);
        drain();
        check("streaming peak occupancy", max_occ, 5);

        out_ready = 0;
        a0 = acc_cnt;
        o0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    bx = $urandom;
                    bm = i[0];
                    send(bx, bm, 32'(model(64'(bx), bm, 32)));
                end
            end
            begin
                repeat (12) @(posedge clk);
                #2;
                check("backpressure in_ready", in_ready, 0);
                check("backpressure occupancy", occupancy, 5);
                check("backpressure accepts", acc_cnt - a0, 5);
                out_ready = 1;
            end
        join
        drain();
        check("backpressure emitted", out_cnt - o0, 8);

        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    bx = $urandom;
                    bm = i[0];
                    send(bx, bm, 32'(model(64'(bx), bm, 32)));
                    repeat (i % 3) @(posedge clk);
                    #1;
                end
            end
            begin
                repeat (5) @(posedge clk);
                #2;
                out_ready = 0;
                @(posedge clk);
                #2;
                out_ready = 1;
            end
        join
        drain();

        for (int i = 0; i < 3; i++) send(32'h100 + i, 1'b0, 32'(model(64'(32'h100 + i), 1'b0, 32)));
        nrst = 0;
        #1;
        check("mid reset out_valid", out_valid, 0);
        check("mid reset occupancy", occupancy, 0);
        check("mid reset busy", busy, 0);
        sb.delete();
        @(posedge clk);
        #1;
        nrst = 1;
        @(posedge clk);
        #1;
        send(32'h3, 1'b0, 32'h2);
        measure_latency();
        drain();

        fork
            begin
                for (int i = 0; i < 256; i++) begin
                    v7 = 1;
                    d7 = i[6:0];
                    m7 = i[7];
                    @(posedge clk);
                    #1;
                end
                v7 = 0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    v1 = 1;
                    d1 = i[0];
                    m1 = i[1];
                    @(posedge clk);
                    #1;
                end
                v1 = 0;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("w7 outputs", out7_cnt, 256);
        check("w1 outputs", out1_cnt, 4);
        check("w7 idle busy", b7, 0);
        check("w7 idle occupancy", oc7, 0);
        check("w1 idle busy", b1, 0);
        check("w1 idle occupancy", oc1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
